// File: rtl/reg_pattern_checker.sv
// reg_pattern_checker
//   Response checker on the output side of the ten-bit register. Accepts register output
//   samples and compares them in order against a fixed six-entry pattern sequence:
//     0 all ones, 1 all zeros, 2 even bits set, 3 odd bits set,
//     4 upper half ones, 5 lower half ones.
//   Reports pass/fail, a saturating error count and details of the first mismatch.
//
// Parameters
//   WIDTH    data width, must be even (half-word patterns)
//   CNT_W    errCount width, saturates at 2**CNT_W-1
//   TIMEOUT  idle CHECK cycles tolerated between samples (CHECKER_TIMEOUT_EN only)
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         pulse; begins a run from IDLE or DONE, ignored while busy
//   dataValid     dataIn carries a sample this cycle
//   dataIn        register output sample
//   busy          run in progress
//   done          run finished, held until the next accepted start
//   pass          done with zero errors and no timeout
//   errCount      mismatching samples in current/last run
//   patIndex      index of next expected pattern
//   firstErrIdx   pattern index of first mismatch
//   firstErrBits  dataIn ^ expected at first mismatch
//   timedOut      run ended by idle timeout
//
// Configuration
//   CHECKER_TIMEOUT_EN  when defined, a run ends after TIMEOUT consecutive CHECK cycles
//                       without dataValid. Otherwise timedOut is tied to 0.

module reg_pattern_checker #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dataValid,
  input  logic [WIDTH-1:0] dataIn,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] errCount,
  output logic [2:0]       patIndex,
  output logic [2:0]       firstErrIdx,
  output logic [WIDTH-1:0] firstErrBits,
  output logic             timedOut
);

  typedef enum logic [1:0] {StIdle, StCheck, StDone} state_e;

  state_e state_q;

  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] diff;
  logic             mismatch;
  logic [CNT_W-1:0] err_next;

  // Expected pattern for the current index.
  always_comb begin
    expected = '0;
    case (patIndex)
      3'd0: expected = '1;
      3'd1: expected = '0;
      3'd2: for (int i = 0; i < int'(WIDTH); i++) expected[i] = ~i[0];
      3'd3: for (int i = 0; i < int'(WIDTH); i++) expected[i] = i[0];
      3'd4: for (int i = 0; i < int'(WIDTH); i++) expected[i] = (i >= int'(WIDTH / 2));
      3'd5: for (int i = 0; i < int'(WIDTH); i++) expected[i] = (i < int'(WIDTH / 2));
      default: expected = '0;
    endcase
  end

  assign diff     = dataIn ^ expected;
  assign mismatch = |diff;

  // Saturating increment on mismatch.
  always_comb begin
    err_next = errCount;
    if (mismatch && !(&errCount)) err_next = errCount + CNT_W'(1);
  end

`ifdef CHECKER_TIMEOUT_EN
  localparam int unsigned IdleW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [IdleW-1:0] idle_q;
`else
  assign timedOut = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      errCount     <= '0;
      patIndex     <= 3'd0;
      firstErrIdx  <= 3'd0;
      firstErrBits <= '0;
`ifdef CHECKER_TIMEOUT_EN
      timedOut     <= 1'b0;
      idle_q       <= '0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          // A sample arriving together with start is discarded.
          if (start) begin
            state_q      <= StCheck;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            errCount     <= '0;
            patIndex     <= 3'd0;
            firstErrIdx  <= 3'd0;
            firstErrBits <= '0;
`ifdef CHECKER_TIMEOUT_EN
            timedOut     <= 1'b0;
            idle_q       <= '0;
`endif
          end
        end

        StCheck: begin
          if (dataValid) begin
            errCount <= err_next;
            if (mismatch && (errCount == '0)) begin
              firstErrIdx  <= patIndex;
              firstErrBits <= diff;
            end
`ifdef CHECKER_TIMEOUT_EN
            idle_q <= '0;
`endif
            if (patIndex == 3'd5) begin
              state_q  <= StDone;
              patIndex <= 3'd0;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= (err_next == '0);
            end else begin
              patIndex <= patIndex + 3'd1;
            end
          end
`ifdef CHECKER_TIMEOUT_EN
          // This cycle is the TIMEOUT-th consecutive idle one.
          else if (idle_q == IdleW'(TIMEOUT - 1)) begin
            state_q  <= StDone;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
            timedOut <= 1'b1;
          end else begin
            idle_q <= idle_q + IdleW'(1);
          end
`endif
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
